// File: rtl/mmap_arb_if.sv
// mmap_arb_if: requester handshakes plus register-port write bus of mmap_arb.
//   req0/req1 : valid/data in, ready out (ready is the only combinational output)
//   o_addr    : 0 = ctrl register, 1 = data register
//   o_we      : write strobe
//   o_data    : write data
//   o_owner   : requester id of the current/last transaction
//   o_busy    : sequencer is in CTRL, DATA or GAP
//   o_done    : one-cycle pulse during the data beat
// slave  = arbiter side, master = requesters + register slave side.
interface mmap_arb_if #(
  parameter int DATA_W = 32
);
  logic              i_req0_valid;
  logic [DATA_W-1:0] i_req0_data;
  logic              o_req0_ready;
  logic              i_req1_valid;
  logic [DATA_W-1:0] i_req1_data;
  logic              o_req1_ready;
  logic              o_addr;
  logic              o_we;
  logic [DATA_W-1:0] o_data;
  logic              o_owner;
  logic              o_busy;
  logic              o_done;

  modport slave (
    input  i_req0_valid, i_req0_data, i_req1_valid, i_req1_data,
    output o_req0_ready, o_req1_ready, o_addr, o_we, o_data, o_owner, o_busy, o_done
  );

  modport master (
    output i_req0_valid, i_req0_data, i_req1_valid, i_req1_data,
    input  o_req0_ready, o_req1_ready, o_addr, o_we, o_data, o_owner, o_busy, o_done
  );
endinterface

// File: rtl/mmap_arb.sv
// mmap_arb: two-requester round-robin arbiter/sequencer for the accelerator
// register port. Each accepted word becomes a ctrl write (addr 0, data
// {0.., owner, 1}) followed by a data write (addr 1, latched word), then
// GAP_CYCLES idle cycles before the next grant.
//   i_clk : clock, rising edge
//   i_rst : asynchronous active-low reset
//   bus   : mmap_arb_if.slave (requester handshakes + write bus)
// GAP_CYCLES must lie in 0..15 (4-bit gap counter).
module mmap_arb #(
  parameter int DATA_W     = 32,
  parameter int GAP_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  mmap_arb_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, CTRL, DATA, GAP} state_t;

  localparam int         GAP_INIT_I = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [3:0] GAP_INIT   = GAP_INIT_I[3:0];

  state_t            state_q, state_d;
  logic [DATA_W-1:0] word_q,  word_d;
  logic              owner_q, owner_d;
  logic              ptr_q,   ptr_d;   // last granted requester
  logic [3:0]        cnt_q,   cnt_d;

  logic sel;
  logic rdy0, rdy1;

  // Grant selection and ready: the only input-to-output combinational path.
  always_comb begin
    sel  = (bus.i_req0_valid && bus.i_req1_valid) ? ~ptr_q : bus.i_req1_valid;
    rdy0 = i_rst && (state_q == IDLE) && bus.i_req0_valid && !sel;
    rdy1 = i_rst && (state_q == IDLE) && bus.i_req1_valid &&  sel;
  end

  assign bus.o_req0_ready = rdy0;
  assign bus.o_req1_ready = rdy1;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (rdy0 || rdy1) begin
          word_d  = sel ? bus.i_req1_data : bus.i_req0_data;
          owner_d = sel;
          ptr_d   = sel;
          state_d = CTRL;
        end
      end
      CTRL: state_d = DATA;
      DATA: begin
        if (GAP_CYCLES > 0) begin
          state_d = GAP;
          cnt_d   = GAP_INIT;
        end else begin
          state_d = IDLE;
        end
      end
      GAP: begin
        if (cnt_q == 4'd0) state_d = IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= IDLE;
      word_q  <= '0;
      owner_q <= 1'b0;
      ptr_q   <= 1'b1;  // requester 0 wins the first contended grant
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Write bus decoded from registered state only, so an asserted reset
  // drops o_we at once and no beat is ever replayed.
  always_comb begin
    bus.o_we    = 1'b0;
    bus.o_addr  = 1'b0;
    bus.o_data  = '0;
    bus.o_done  = 1'b0;
    bus.o_busy  = (state_q != IDLE);
    bus.o_owner = owner_q;
    case (state_q)
      CTRL: begin
        bus.o_we   = 1'b1;
        bus.o_data = {{(DATA_W-2){1'b0}}, owner_q, 1'b1};
      end
      DATA: begin
        bus.o_we   = 1'b1;
        bus.o_addr = 1'b1;
        bus.o_data = word_q;
        bus.o_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mmap_arb.sv
module tb_mmap_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst2, rst0;

  mmap_arb_if #(.DATA_W(32)) b2 ();
  mmap_arb_if #(.DATA_W(32)) b0 ();

  mmap_arb #(.DATA_W(32), .GAP_CYCLES(2)) dut2 (.i_clk(clk), .i_rst(rst2), .bus(b2));
  mmap_arb #(.DATA_W(32), .GAP_CYCLES(0)) dut0 (.i_clk(clk), .i_rst(rst0), .bus(b0));

  typedef struct packed {
    logic        addr;
    logic [31:0] data;
    logic        owner;
  } beat_t;

  beat_t q2[$];
  beat_t q0[$];

  int checks = 0;
  int passes = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Scoreboard monitors: every write beat must match the next expected beat.
  always @(negedge clk) begin
    beat_t e;
    if (b2.o_we) begin
      if (q2.size() == 0) begin
        checks++;
        $display("FAIL dut2_unexpected_write: got addr=%0d data=%h expected no write", b2.o_addr, b2.o_data);
      end else begin
        e = q2.pop_front();
        chk("dut2_addr",  {31'b0, b2.o_addr},  {31'b0, e.addr});
        chk("dut2_data",  b2.o_data,           e.data);
        chk("dut2_owner", {31'b0, b2.o_owner}, {31'b0, e.owner});
        chk("dut2_done",  {31'b0, b2.o_done},  {31'b0, e.addr});
      end
    end
  end

  always @(negedge clk) begin
    beat_t e;
    if (b0.o_we) begin
      if (q0.size() == 0) begin
        checks++;
        $display("FAIL dut0_unexpected_write: got addr=%0d data=%h expected no write", b0.o_addr, b0.o_data);
      end else begin
        e = q0.pop_front();
        chk("dut0_addr",  {31'b0, b0.o_addr},  {31'b0, e.addr});
        chk("dut0_data",  b0.o_data,           e.data);
        chk("dut0_owner", {31'b0, b0.o_owner}, {31'b0, e.owner});
        chk("dut0_done",  {31'b0, b0.o_done},  {31'b0, e.addr});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic rdy(input int d, input int n);
    if (d == 2) return (n == 0) ? b2.o_req0_ready : b2.o_req1_ready;
    return (n == 0) ? b0.o_req0_ready : b0.o_req1_ready;
  endfunction

  function automatic logic busy(input int d);
    return (d == 2) ? b2.o_busy : b0.o_busy;
  endfunction

  task automatic push(input int d, input logic own, input logic [31:0] w);
    beat_t c, b;
    c.addr = 1'b0; c.data = {30'b0, own, 1'b1}; c.owner = own;
    b.addr = 1'b1; b.data = w;                  b.owner = own;
    if (d == 2) begin q2.push_back(c); q2.push_back(b); end
    else        begin q0.push_back(c); q0.push_back(b); end
  endtask

  // Called at drive time (+1 after an edge). Waits for a grant, checks how
  // many cycles it took and who got it, queues the two expected beats, then
  // steps past the handshake edge.
  task automatic await_g(input int d, input logic own, input logic [31:0] w, input int lat);
    int n = 0;
    #3;
    while (!(rdy(d, 0) || rdy(d, 1)) && n < 20) begin
      cyc();
      #3;
      n++;
    end
    chk($sformatf("dut%0d_grant_latency", d), n, lat);
    chk($sformatf("dut%0d_grant_ready0", d), {31'b0, rdy(d, 0)}, {31'b0, !own});
    chk($sformatf("dut%0d_grant_ready1", d), {31'b0, rdy(d, 1)}, {31'b0, own});
    chk($sformatf("dut%0d_grant_busy", d),   {31'b0, busy(d)},   32'd0);
    push(d, own, w);
    cyc();
  endtask

  initial begin
    rst2 = 1'b0;
    rst0 = 1'b0;
    b2.i_req0_valid = 1'b1; b2.i_req0_data = 32'h12345678;
    b2.i_req1_valid = 1'b0; b2.i_req1_data = 32'h0;
    b0.i_req0_valid = 1'b0; b0.i_req0_data = 32'h0;
    b0.i_req1_valid = 1'b0; b0.i_req1_data = 32'h0;

    // Reset state, ready forced low even with valid asserted.
    cyc();
    #3;
    chk("rst_we",     {31'b0, b2.o_we},       32'd0);
    chk("rst_addr",   {31'b0, b2.o_addr},     32'd0);
    chk("rst_data",   b2.o_data,              32'd0);
    chk("rst_owner",  {31'b0, b2.o_owner},    32'd0);
    chk("rst_busy",   {31'b0, b2.o_busy},     32'd0);
    chk("rst_done",   {31'b0, b2.o_done},     32'd0);
    chk("rst_ready0", {31'b0, b2.o_req0_ready}, 32'd0);
    chk("rst_ready1", {31'b0, b2.o_req1_ready}, 32'd0);
    chk("rst0_busy",  {31'b0, b0.o_busy},     32'd0);

    // First transaction right after release, then req0 held through the gap.
    cyc();
    rst2 = 1'b1;
    rst0 = 1'b1;
    await_g(2, 1'b0, 32'h12345678, 0);
    for (int k = 0; k < 3; k++) begin
      #3;
      chk("held_ready0", {31'b0, b2.o_req0_ready}, 32'd0);
      chk("held_busy",   {31'b0, b2.o_busy},       32'd1);
      cyc();
    end
    b2.i_req0_data = 32'h11111111;
    await_g(2, 1'b0, 32'h11111111, 1);

    // In CTRL: change the word under the latch; switch to req1 only.
    b2.i_req0_data  = 32'h22222222;
    b2.i_req0_valid = 1'b0;
    b2.i_req1_valid = 1'b1;
    b2.i_req1_data  = 32'h0000BBBB;
    await_g(2, 1'b1, 32'h0000BBBB, 4);
    await_g(2, 1'b1, 32'h0000BBBB, 4);
    await_g(2, 1'b1, 32'h0000BBBB, 4);

    // Both valid: strict alternation starting with req0.
    b2.i_req0_valid = 1'b1;
    b2.i_req0_data  = 32'hAAAA0000;
    await_g(2, 1'b0, 32'hAAAA0000, 4);
    await_g(2, 1'b1, 32'h0000BBBB, 4);
    await_g(2, 1'b0, 32'hAAAA0000, 4);

    // Reset during the DATA beat of that last req0 transaction.
    cyc();
    #1;
    chk("pre_rst_we", {31'b0, b2.o_we}, 32'd1);
    void'(q2.pop_back());
    rst2 = 1'b0;
    #1;
    chk("mid_rst_we",     {31'b0, b2.o_we},         32'd0);
    chk("mid_rst_busy",   {31'b0, b2.o_busy},       32'd0);
    chk("mid_rst_done",   {31'b0, b2.o_done},       32'd0);
    chk("mid_rst_ready0", {31'b0, b2.o_req0_ready}, 32'd0);
    chk("mid_rst_ready1", {31'b0, b2.o_req1_ready}, 32'd0);
    cyc();
    rst2 = 1'b1;
    await_g(2, 1'b0, 32'hAAAA0000, 0);
    b2.i_req0_valid = 1'b0;
    b2.i_req1_valid = 1'b0;

    // GAP_CYCLES = 0: a held requester is re-granted every 3 cycles.
    b0.i_req0_valid = 1'b1;
    b0.i_req0_data  = 32'h5A5A5A5A;
    await_g(0, 1'b0, 32'h5A5A5A5A, 0);
    await_g(0, 1'b0, 32'h5A5A5A5A, 2);
    b0.i_req0_data  = 32'hC3C3C3C3;
    await_g(0, 1'b0, 32'hC3C3C3C3, 2);
    b0.i_req0_valid = 1'b0;

    repeat (8) cyc();
    #3;
    chk("dut2_idle_busy",   {31'b0, b2.o_busy}, 32'd0);
    chk("dut0_idle_busy",   {31'b0, b0.o_busy}, 32'd0);
    chk("dut2_queue_empty", q2.size(), 32'd0);
    chk("dut0_queue_empty", q0.size(), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
